// File: rtl/bidir_bus_arbiter.sv
// Round-robin owner sequencer for a shared tristate pad bus with keeper.
// Owners get write (drive) or read (sample) bursts, separated by released turnaround cycles.
module bidir_bus_arbiter #(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 8,
    parameter int TA      = 1,
    parameter int MAXHOLD = 16
) (
    input  logic                    CLK,
    input  logic                    RSTN,
    input  logic [NREQ-1:0]         REQ,
    input  logic [NREQ-1:0]         WR,
    input  logic [NREQ*WIDTH-1:0]   WDATA,
    output logic [NREQ-1:0]         GNT,
    output logic [WIDTH-1:0]        RDATA,
    output logic                    RVALID,
    output logic                    BUSY,
    output logic [WIDTH-1:0]        I,
    output logic                    T,
    input  logic [WIDTH-1:0]        O
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, OWN, TURN} state_t;

    state_t            state, state_nx;
    logic [IW-1:0]     rr, rr_nx, own, own_nx, sel;
    logic              found;
    logic              dir, dir_nx;
    logic [7:0]        cnt, cnt_nx;
    logic [2:0]        tcnt, tcnt_nx;
    logic [NREQ-1:0]   gnt_nx;
    logic [WIDTH-1:0]  i_nx;
    logic              t_nx;

    // First requester at or above the rr pointer, wrapping.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (!found && REQ[(int'(rr) + j) % NREQ]) begin
                found = 1'b1;
                sel   = IW'((int'(rr) + j) % NREQ);
            end
        end
    end

    always_comb begin
        state_nx = state;
        rr_nx    = rr;
        own_nx   = own;
        dir_nx   = dir;
        cnt_nx   = cnt;
        tcnt_nx  = tcnt;
        gnt_nx   = GNT;
        i_nx     = I;
        t_nx     = T;
        case (state)
            IDLE: begin
                if (found) begin
                    gnt_nx      = '0;
                    gnt_nx[sel] = 1'b1;
                    own_nx      = sel;
                    dir_nx      = WR[sel];
                    cnt_nx      = 8'd1;
                    rr_nx       = IW'((int'(sel) + 1) % NREQ);
                    state_nx    = OWN;
                    if (WR[sel]) begin
                        t_nx = 1'b0;
                        i_nx = WDATA[int'(sel)*WIDTH +: WIDTH];
                    end
                end
            end
            OWN: begin
                // I keeps its last value on release so the keeper sees no glitch.
                if (!REQ[own] || cnt >= 8'(MAXHOLD)) begin
                    gnt_nx = '0;
                    t_nx   = 1'b1;
                    if (TA > 0) begin
                        state_nx = TURN;
                        tcnt_nx  = 3'(TA);
                    end else begin
                        state_nx = IDLE;
                    end
                end else begin
                    cnt_nx = cnt + 8'd1;
                    if (dir) i_nx = WDATA[int'(own)*WIDTH +: WIDTH];
                end
            end
            TURN: begin
                if (tcnt <= 3'd1) state_nx = IDLE;
                else              tcnt_nx  = tcnt - 3'd1;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state  <= IDLE;
            rr     <= '0;
            own    <= '0;
            dir    <= 1'b0;
            cnt    <= '0;
            tcnt   <= '0;
            GNT    <= '0;
            I      <= '0;
            T      <= 1'b1;
            RDATA  <= '0;
            RVALID <= 1'b0;
            BUSY   <= 1'b0;
        end else begin
            state  <= state_nx;
            rr     <= rr_nx;
            own    <= own_nx;
            dir    <= dir_nx;
            cnt    <= cnt_nx;
            tcnt   <= tcnt_nx;
            GNT    <= gnt_nx;
            I      <= i_nx;
            T      <= t_nx;
            BUSY   <= (state_nx != IDLE);
            // A read owner is sampled on every edge it held the grant, release edge included.
            if ((|GNT) && !dir) begin
                RDATA  <= O;
                RVALID <= 1'b1;
            end else begin
                RVALID <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bidir_bus_arbiter.sv
// Directed bench for bidir_bus_arbiter: three parameterizations share stimulus,
// expected beats/grants flow through scoreboard queues.
module tb_bidir_bus_arbiter;

    logic        CLK, RSTN;
    logic [3:0]  REQ, WR;
    logic [31:0] WDATA;
    logic [7:0]  O, keep, ext_val;
    logic        ext_en;

    logic [3:0] gnt_a, gnt_b, gnt_c;
    logic [7:0] rdata_a, rdata_b, rdata_c, i_a, i_b, i_c;
    logic       rvalid_a, rvalid_b, rvalid_c, busy_a, busy_b, busy_c, t_a, t_b, t_c;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] wq[$];
    logic [31:0] rq[$];
    logic [31:0] gq[$];

    bidir_bus_arbiter #(.NREQ(4), .WIDTH(8), .TA(1), .MAXHOLD(16)) u_a (
        .CLK(CLK), .RSTN(RSTN), .REQ(REQ), .WR(WR), .WDATA(WDATA), .GNT(gnt_a),
        .RDATA(rdata_a), .RVALID(rvalid_a), .BUSY(busy_a), .I(i_a), .T(t_a), .O(O));
    bidir_bus_arbiter #(.NREQ(4), .WIDTH(8), .TA(1), .MAXHOLD(2)) u_b (
        .CLK(CLK), .RSTN(RSTN), .REQ(REQ), .WR(WR), .WDATA(WDATA), .GNT(gnt_b),
        .RDATA(rdata_b), .RVALID(rvalid_b), .BUSY(busy_b), .I(i_b), .T(t_b), .O(O));
    bidir_bus_arbiter #(.NREQ(4), .WIDTH(8), .TA(0), .MAXHOLD(1)) u_c (
        .CLK(CLK), .RSTN(RSTN), .REQ(REQ), .WR(WR), .WDATA(WDATA), .GNT(gnt_c),
        .RDATA(rdata_c), .RVALID(rvalid_c), .BUSY(busy_c), .I(i_c), .T(t_c), .O(O));

    // Pad with keeper, driven by instance a or by an external device when released.
    always_latch begin
        if (!t_a)        keep <= i_a;
        else if (ext_en) keep <= ext_val;
    end
    assign O = keep;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RSTN = 1'b0;
        REQ  = '0;
        WR   = '0;
        step();
        step();
        RSTN = 1'b1;
    endtask

    always @(negedge CLK) begin
        chk("onehot_a", 32'($onehot0(gnt_a)), 32'd1);
        chk("onehot_b", 32'($onehot0(gnt_b)), 32'd1);
        chk("onehot_c", 32'($onehot0(gnt_c)), 32'd1);
        chk("drive_needs_gnt_a", 32'(t_a | (|gnt_a)), 32'd1);
        chk("drive_needs_gnt_c", 32'(t_c | (|gnt_c)), 32'd1);
    end

    initial begin
        logic [31:0] e;
        logic [3:0]  prev;
        int ngr, gap, len;
        logic seen;

        RSTN = 1'b0; REQ = '0; WR = '0; WDATA = '0; ext_en = 1'b1; ext_val = '0;
        step(); step();
        chk("rst_gnt_a", 32'(gnt_a), 0);    chk("rst_t_a", 32'(t_a), 1);
        chk("rst_i_a", 32'(i_a), 0);        chk("rst_rdata_a", 32'(rdata_a), 0);
        chk("rst_rvalid_a", 32'(rvalid_a), 0); chk("rst_busy_a", 32'(busy_a), 0);
        chk("rst_b", 32'({gnt_b, t_b, i_b, rdata_b, rvalid_b, busy_b}), 32'h0_1_00_00_0_0 >> 0 & 32'hFFFFFFFF ? {4'h0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0} : 0);
        chk("rst_c", 32'({gnt_c, t_c, i_c, rdata_c, rvalid_c, busy_c}), 32'({4'h0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0}));

        // Async reset in the middle of a write burst.
        RSTN = 1'b1; REQ = 4'b0001; WR = 4'b0001; WDATA[7:0] = 8'h11;
        step();
        chk("burst_gnt", 32'(gnt_a), 32'h1); chk("burst_t", 32'(t_a), 0); chk("burst_i", 32'(i_a), 32'h11);
        #2 RSTN = 1'b0;
        #1;
        chk("midrst_t", 32'(t_a), 1);   chk("midrst_gnt", 32'(gnt_a), 0);
        chk("midrst_rvalid", 32'(rvalid_a), 0); chk("midrst_busy", 32'(busy_a), 0);
        REQ = 4'hF; WDATA[7:0] = 8'h22;
        step();
        RSTN = 1'b1;
        step();
        chk("postrst_gnt", 32'(gnt_a), 32'h1); chk("postrst_i", 32'(i_a), 32'h22);

        // Single write burst from requester 1.
        do_reset();
        REQ = 4'b0010; WR = 4'b0010; WDATA[15:8] = 8'hA1; wq.push_back(32'hA1);
        for (int b = 0; b < 3; b++) begin
            step();
            chk("wr_gnt", 32'(gnt_a), 32'h2); chk("wr_t", 32'(t_a), 0); chk("wr_busy", 32'(busy_a), 1);
            chk("wr_q_avail", 32'(wq.size() > 0), 1);
            e = (wq.size() > 0) ? wq.pop_front() : 32'hFFFF_FFFF;
            chk("wr_i", 32'(i_a), e);
            if (b < 2) begin
                WDATA[15:8] = 8'hA2 + 8'(b);
                wq.push_back(32'(8'hA2 + 8'(b)));
            end else begin
                REQ = '0;
            end
        end
        step();
        chk("wr_rel_gnt", 32'(gnt_a), 0); chk("wr_rel_t", 32'(t_a), 1);
        chk("wr_rel_busy", 32'(busy_a), 1); chk("wr_rel_i", 32'(i_a), 32'hA3);
        step();
        chk("wr_idle_busy", 32'(busy_a), 0); chk("wr_idle_t", 32'(t_a), 1);

        // Single two-beat read from requester 2.
        do_reset();
        ext_en = 1'b1; ext_val = 8'h00; REQ = 4'b0100; WR = '0;
        step();
        chk("rd_gnt", 32'(gnt_a), 32'h4); chk("rd_t", 32'(t_a), 1); chk("rd_rvalid0", 32'(rvalid_a), 0);
        ext_val = 8'h5A; rq.push_back(32'h5A);
        step();
        chk("rd_rvalid1", 32'(rvalid_a), 1);
        e = (rq.size() > 0) ? rq.pop_front() : 32'hFFFF_FFFF;
        chk("rd_data1", 32'(rdata_a), e);
        ext_val = 8'h3C; rq.push_back(32'h3C); REQ = '0;
        step();
        chk("rd_rvalid2", 32'(rvalid_a), 1);
        e = (rq.size() > 0) ? rq.pop_front() : 32'hFFFF_FFFF;
        chk("rd_data2", 32'(rdata_a), e);
        chk("rd_rel_gnt", 32'(gnt_a), 0); chk("rd_rel_t", 32'(t_a), 1);
        step();
        chk("rd_rvalid_end", 32'(rvalid_a), 0);

        // Round robin with MAXHOLD=2 on instance b.
        do_reset();
        REQ = 4'hF; WR = '0;
        gq = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0};
        prev = '0; ngr = 0; gap = 0; len = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (gnt_b != 0 && prev == 0) begin
                if (ngr > 0) chk("rr_gap", 32'(gap), 32'd2);
                gap = 0; len = 0;
                chk("rr_q_avail", 32'(gq.size() > 0), 1);
                e = (gq.size() > 0) ? gq.pop_front() : 32'd31;
                chk("rr_order", 32'(gnt_b), 32'd1 << e);
                chk("rr_busy", 32'(busy_b), 1);
                ngr++;
            end
            if (gnt_b != 0) len++;
            if (gnt_b == 0 && prev != 0) chk("rr_len", 32'(len), 32'd2);
            if (gnt_b == 0) gap++;
            prev = gnt_b;
            if (ngr == 5 && gnt_b == 0) break;
        end
        chk("rr_grants", 32'(ngr), 32'd5);
        chk("rr_q_empty", 32'(gq.size()), 0);

        // Write by 0 followed by a queued read by 1; first read sees the keeper level.
        do_reset();
        ext_en = 1'b0; REQ = 4'b0011; WR = 4'b0001; WDATA[7:0] = 8'h77;
        step();
        chk("wr2rd_gnt0", 32'(gnt_a), 32'h1); chk("wr2rd_t0", 32'(t_a), 0); chk("wr2rd_i0", 32'(i_a), 32'h77);
        rq.push_back(32'h77);
        REQ = 4'b0010;
        step();
        chk("wr2rd_rel_t", 32'(t_a), 1); chk("wr2rd_rel_gnt", 32'(gnt_a), 0);
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            step();
            chk("wr2rd_no_drive_on_read", 32'(gnt_a[1] & ~t_a), 0);
            if (gnt_a[1]) REQ = '0;
            if (rvalid_a) begin
                e = (rq.size() > 0) ? rq.pop_front() : 32'hFFFF_FFFF;
                chk("wr2rd_keeper_rdata", 32'(rdata_a), e);
                seen = 1'b1;
                break;
            end
        end
        chk("wr2rd_rvalid_seen", 32'(seen), 1);
        ext_en = 1'b1;

        // TA=0, MAXHOLD=1 on instance c: one beat per grant, grant toggles.
        do_reset();
        REQ = 4'b0001; WR = 4'b0001; WDATA[7:0] = 8'hC1; wq.delete(); wq.push_back(32'hC1);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("ta0_gnt", 32'(gnt_c), (k % 2 == 0) ? 32'h1 : 32'h0);
            chk("ta0_busy", 32'(busy_c), 32'(gnt_c[0]));
            if (gnt_c[0]) begin
                chk("ta0_t", 32'(t_c), 0);
                e = (wq.size() > 0) ? wq.pop_front() : 32'hFFFF_FFFF;
                chk("ta0_i", 32'(i_c), e);
                WDATA[7:0] = WDATA[7:0] + 8'd1;
                wq.push_back(32'(WDATA[7:0]));
            end else begin
                chk("ta0_rel_t", 32'(t_c), 1);
            end
        end
        REQ = '0;
        wq.delete();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/bidir_bus_arbiter.md
Name: bidir_bus_arbiter

Overview:
- Round-robin arbiter and sequencer for one shared bidirectional pad bus built from bidirectional buffer cells with bus-keeper.
- Grants the bus to one of NREQ requesters for write (drive) or read (sample) bursts.
- Drives the buffer enable (T) and data (I), and samples the pad return (O).
- Inserts TA turnaround cycles with the bus released (T=1, keeper holds last level) between owners, so two drivers never overlap.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, bus width in bits.
- TA, 1, turnaround cycles between ownerships (0..7).
- MAXHOLD, 16, maximum beats per grant (1..255).

Ports:
- CLK  input  1  clock; all state on rising edge.
- RSTN  input  1  asynchronous active-low reset.
- REQ  input  NREQ  per-requester request; held while bursting.
- WR  input  NREQ  per-requester direction: 1 write/drive, 0 read; sampled at grant edge only.
- WDATA  input  NREQ*WIDTH  write data; requester i on bits [i*WIDTH +: WIDTH].
- GNT  output  NREQ  one-hot registered grant.
- RDATA  output  WIDTH  registered sample of O.
- RVALID  output  1  RDATA holds a new read beat this cycle.
- BUSY  output  1  state is not IDLE.
- I  output  WIDTH  to buffer data input.
- T  output  1  to buffer tristate control; 1 = released.
- O  input  WIDTH  from buffer pad return.

Behaviour:
- Reset (async, RSTN=0):
  - GNT=0, T=1, I=0, RDATA=0, RVALID=0, BUSY=0.
  - State IDLE; rr pointer=0; beat counter cnt=0; dir=0.
  - Reset mid-burst releases the bus at once (T=1 asynchronously).
- All outputs are registered; there are no combinational paths from inputs to outputs.
- States: IDLE, OWN, TURN.
- IDLE:
  - If any REQ is set, select the first set bit scanning from rr pointer upward with wrap.
  - At that edge: GNT[sel]=1, dir=WR[sel], cnt=1, rr pointer=(sel+1) mod NREQ, go to OWN.
  - If dir=1: T<=0 and I<=WDATA[sel] at the same edge. If dir=0: T stays 1.
  - Grant latency is 1 edge from a sampled REQ.
- OWN, per edge, with owner k:
  - If REQ[k]=0 or cnt==MAXHOLD: release. GNT<=0, T<=1, I holds its value.
    - If TA>0, go to TURN with tcnt=TA; else go to IDLE.
  - Otherwise, write (dir=1): I<=WDATA[k], cnt<=cnt+1. Read (dir=0): cnt<=cnt+1.
- Read sampling: at every edge where GNT[k]=1 before the edge and dir=0, RDATA<=O and RVALID<=1. This includes the release edge, so a read grant of n beats yields n RVALID pulses starting 1 cycle after GNT rises. At all other edges RVALID<=0.
- Write handshake: WDATA[k] is consumed at every edge after which GNT[k]=1 (grant edge included). The requester presents its next beat after each such edge. A write grant of n edges with GNT high yields n driven beats.
- TURN:
  - GNT=0, T=1; tcnt decrements each edge; go to IDLE when tcnt reaches 1.
  - No request is granted during TURN; pending REQs wait.
  - Minimum gap between ownerships is TA+1 cycles with GNT all 0 (the IDLE arbitration edge included).
- Boundaries and simultaneous events:
  - WR and REQ changes of non-owners during OWN/TURN are ignored.
  - The owner's WR is ignored after the grant edge.
  - A requester that drops REQ before grant is simply not selected.
  - The owner re-requesting after release competes normally; rr already points past it.
  - cnt saturates at MAXHOLD and cannot wrap.
  - T=0 only in OWN with dir=1.
  - GNT is never multi-hot.

Test Plan:
- Reset: hold RSTN=0 mid write burst (REQ0=1, WR0=1) -> T=1 and GNT=0 immediately; RVALID=0; after release, first grant goes to REQ0 (pointer 0).
- Single write: REQ1=1, WR1=1, WDATA1 steps 0xA1,0xA2,0xA3, drop REQ after 3 GNT edges -> I=0xA1,0xA2,0xA3 on consecutive cycles with T=0; then T=1 for TA=1 cycle plus 1 IDLE cycle; BUSY drops accordingly.
- Single read: REQ2=1, WR2=0, O driven 0x5A then 0x3C, 2 beats -> T stays 1; RVALID pulses 2 cycles starting 1 cycle after GNT rises; RDATA=0x5A,0x3C.
- Round robin: REQ0..3 all held, MAXHOLD=2 -> grant order 0,1,2,3,0; each grant exactly 2 GNT cycles; no GNT overlap; gap of TA+1 cycles between grants.
- Write-to-read turnaround: REQ0 write, then REQ1 read queued -> T goes 1 at the release edge; no cycle has T=0 while GNT1=1; keeper-held value appears on the first RDATA if O is undriven.
- TA=0, MAXHOLD=1: single requester held -> GNT toggles 1,0,1,0; one beat per grant; cnt never exceeds 1.
